// File: rtl/led_serial_tx_if.sv
// Host/chain signal bundle for led_serial_tx. The pend signal exists only
// when LED_SERIAL_TX_PEND_EN is defined.
interface led_serial_tx_if #(
    parameter int DW = 16
) ();
    logic          start;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic          led_clk;
    logic          led_sout;
    logic          led_clrn;
    logic          led_pen;
`ifdef LED_SERIAL_TX_PEND_EN
    logic          pend;
`endif

    modport master (
        output start, data,
        input  busy, done, led_clk, led_sout, led_clrn, led_pen
`ifdef LED_SERIAL_TX_PEND_EN
        , input pend
`endif
    );

    modport slave (
        input  start, data,
        output busy, done, led_clk, led_sout, led_clrn, led_pen
`ifdef LED_SERIAL_TX_PEND_EN
        , output pend
`endif
    );
endinterface

// File: rtl/led_serial_tx.sv
// Serial transmit engine: shifts a DW-bit word MSB-first into a 74HC164-style
// chain, then pulses led_pen. Optional one-deep request buffer: LED_SERIAL_TX_PEND_EN.
module led_serial_tx #(
    parameter int DW  = 16,
    parameter int DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    led_serial_tx_if.slave   bus
);
    localparam int CW  = $clog2(DW + 1);
    localparam int DVW = $clog2(DIV + 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        LATCH = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DVW-1:0]  div_q, div_d;
    logic            half_q, half_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            led_clk_q, led_clk_d;
    logic            led_sout_q, led_sout_d;
    logic            led_clrn_q, led_clrn_d;
    logic            led_pen_q, led_pen_d;
    logic            load_s;
    logic [DW-1:0]   load_word_s;
`ifdef LED_SERIAL_TX_PEND_EN
    logic            pend_q, pend_d;
    logic [DW-1:0]   pend_data_q, pend_data_d;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        half_d      = half_q;
        load_s      = 1'b0;
        load_word_s = bus.data;
        led_clrn_d  = 1'b1;
`ifdef LED_SERIAL_TX_PEND_EN
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef LED_SERIAL_TX_PEND_EN
                if (pend_q) begin
                    load_s      = 1'b1;
                    load_word_s = pend_data_q;
                    pend_d      = 1'b0;
                end else begin
                    load_s = bus.start;
                end
`else
                load_s = bus.start;
`endif
            end
            SHIFT: begin
                // A bit period is DIV low cycles followed by DIV high cycles.
                if (div_q == DIV_LAST) begin
                    div_d = {DVW{1'b0}};
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        shift_d = {shift_q[DW-2:0], 1'b0};
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = LATCH;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = {DVW{1'b0}};
                    state_d = IDLE;
`ifdef LED_SERIAL_TX_PEND_EN
                    if (pend_q) begin
                        load_s      = 1'b1;
                        load_word_s = pend_data_q;
                        pend_d      = 1'b0;
                    end else begin
                        load_s = 1'b0;
                    end
`endif
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LED_SERIAL_TX_PEND_EN
        // Requests that cannot start now are parked; the newest one wins.
        if (bus.start && ((state_q != IDLE) || pend_q)) begin
            pend_d      = 1'b1;
            pend_data_d = bus.data;
        end else begin
            pend_d = pend_d;
        end
`endif

        if (load_s) begin
            state_d = SHIFT;
            shift_d = load_word_s;
            cnt_d   = {CW{1'b0}};
            div_d   = {DVW{1'b0}};
            half_d  = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d     = (state_d != IDLE);
        led_clk_d  = (state_d == SHIFT) ? half_d : 1'b1;
        led_sout_d = (state_d == SHIFT) ? shift_d[DW-1] : 1'b0;
        led_pen_d  = (state_d == LATCH);
        done_d     = (state_d == LATCH) && (div_d == DIV_LAST);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= {DW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            div_q       <= {DVW{1'b0}};
            half_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            led_clk_q   <= 1'b1;
            led_sout_q  <= 1'b0;
            led_clrn_q  <= 1'b0;
            led_pen_q   <= 1'b0;
`ifdef LED_SERIAL_TX_PEND_EN
            pend_q      <= 1'b0;
            pend_data_q <= {DW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            half_q      <= half_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            led_clk_q   <= led_clk_d;
            led_sout_q  <= led_sout_d;
            led_clrn_q  <= led_clrn_d;
            led_pen_q   <= led_pen_d;
`ifdef LED_SERIAL_TX_PEND_EN
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.led_clk  = led_clk_q;
    assign bus.led_sout = led_sout_q;
    assign bus.led_clrn = led_clrn_q;
    assign bus.led_pen  = led_pen_q;
`ifdef LED_SERIAL_TX_PEND_EN
    assign bus.pend     = pend_q;
`endif
endmodule

// File: tb/tb_led_serial_tx.sv
// Self-checking bench for led_serial_tx (DW=16, DIV=2): vector table, random
// frames against a frame-level model, and hand-written reset/handshake sequences.
module tb_led_serial_tx;
    localparam int DW    = 16;
    localparam int DIV   = 2;
    localparam int FRAME = 2 * DW * DIV + DIV;
`ifdef LED_SERIAL_TX_PEND_EN
    localparam int POKE20 = -1;
`else
    localparam int POKE20 = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_serial_tx_if #(.DW(DW)) bus ();

    led_serial_tx #(.DW(DW), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            poke;
        logic [DW-1:0] exp_bits;
        int            exp_busy;
        int            exp_pen;
        int            exp_edges;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [DW-1:0] w);
        bus.start = 1'b1;
        bus.data  = w;
        tick();
        bus.start = 1'b0;
        bus.data  = DW'($urandom);
    endtask

    // Observes one frame from its first busy cycle through its done cycle.
    task automatic monitor_frame(input int poke, input logic [DW-1:0] poke_data,
                                 output logic [DW-1:0] bits, output int busy_len,
                                 output int done_at, output int pen_cnt,
                                 output int edges, output logic pend_at_done);
        logic prev_clk = 1'b1;
        bit   finished = 1'b0;
        int   k = 0;
        bits = '0; done_at = 0; pen_cnt = 0; edges = 0; pend_at_done = 1'b0;
        while (!finished && k < 400) begin
            if (bus.busy !== 1'b1) break;
            k++;
            if (bus.led_pen === 1'b1) pen_cnt++;
            if (!prev_clk && bus.led_clk === 1'b1) begin
                bits = {bits[DW-2:0], bus.led_sout};
                edges++;
            end
            prev_clk = bus.led_clk;
            if (bus.done === 1'b1) begin
                done_at  = k;
                finished = 1'b1;
`ifdef LED_SERIAL_TX_PEND_EN
                pend_at_done = bus.pend;
`endif
            end
            if (k == poke) begin
                bus.start = 1'b1;
                bus.data  = poke_data;
            end else if (k == poke + 1) begin
                bus.start = 1'b0;
            end
            tick();
        end
        if (poke >= 0) bus.start = 1'b0;
        busy_len = k;
    endtask

    task automatic check_frame(input string tag, input logic [DW-1:0] word, input int poke);
        logic [DW-1:0] bits;
        int busy_len, done_at, pen_cnt, edges;
        logic pend_at_done;
        start_frame(word);
        monitor_frame(poke, DW'($urandom), bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        // Frame-level model: bits arrive MSB first, so the collected word equals the input.
        check({tag, "_bits"},  32'(bits), 32'(word));
        check({tag, "_busy"},  32'(busy_len), 32'(FRAME));
        check({tag, "_done"},  32'(done_at), 32'(FRAME));
        check({tag, "_pen"},   32'(pen_cnt), 32'(DIV));
        check({tag, "_edges"}, 32'(edges), 32'(DW));
        check({tag, "_idle"},  32'(bus.busy), 32'(0));
    endtask

    initial begin
        logic [DW-1:0] bits;
        int busy_len, done_at, pen_cnt, edges;
        logic pend_at_done;

        vecs[0] = '{data: 16'hA5C3, poke: -1,     exp_bits: 16'hA5C3, exp_busy: 66, exp_pen: 2, exp_edges: 16};
        vecs[1] = '{data: 16'h0000, poke: -1,     exp_bits: 16'h0000, exp_busy: 66, exp_pen: 2, exp_edges: 16};
        vecs[2] = '{data: 16'h8001, poke: POKE20, exp_bits: 16'h8001, exp_busy: 66, exp_pen: 2, exp_edges: 16};
        vecs[3] = '{data: 16'h3C96, poke: -1,     exp_bits: 16'h3C96, exp_busy: 66, exp_pen: 2, exp_edges: 16};

        bus.start = 1'b0;
        bus.data  = '0;

        // Reset values and led_clrn release.
        #1 rst = 1'b1;
        #1;
        check("rst_clrn", 32'(bus.led_clrn), 32'(0));
        check("rst_clk",  32'(bus.led_clk),  32'(1));
        check("rst_busy", 32'(bus.busy),     32'(0));
        check("rst_pen",  32'(bus.led_pen),  32'(0));
        check("rst_sout", 32'(bus.led_sout), 32'(0));
        check("rst_done", 32'(bus.done),     32'(0));
        repeat (2) tick();
        check("rst_clrn_held", 32'(bus.led_clrn), 32'(0));
        rst = 1'b0;
        tick();
        check("clrn_release", 32'(bus.led_clrn), 32'(1));
        check("idle_clk",     32'(bus.led_clk),  32'(1));
        check("idle_busy",    32'(bus.busy),     32'(0));

        // Vector table.
        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i].data);
            check($sformatf("vec%0d_first_busy", i), 32'(bus.busy), 32'(1));
            check($sformatf("vec%0d_first_clk", i),  32'(bus.led_clk), 32'(0));
            check($sformatf("vec%0d_first_sout", i), 32'(bus.led_sout), 32'(vecs[i].data[DW-1]));
            monitor_frame(vecs[i].poke, DW'($urandom), bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
            check($sformatf("vec%0d_bits", i),  32'(bits),     32'(vecs[i].exp_bits));
            check($sformatf("vec%0d_busy", i),  32'(busy_len), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i),  32'(done_at),  32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_pen", i),   32'(pen_cnt),  32'(vecs[i].exp_pen));
            check($sformatf("vec%0d_edges", i), 32'(edges),    32'(vecs[i].exp_edges));
            for (int j = 0; j < 3; j++) begin
                check($sformatf("vec%0d_idle%0d", i, j), 32'(bus.busy), 32'(0));
                check($sformatf("vec%0d_nodone%0d", i, j), 32'(bus.done), 32'(0));
                tick();
            end
        end

        // Randomised frames against the frame-level model.
        for (int i = 0; i < 6; i++) begin
`ifdef LED_SERIAL_TX_PEND_EN
            check_frame($sformatf("rnd%0d", i), DW'($urandom), -1);
`else
            check_frame($sformatf("rnd%0d", i), DW'($urandom), int'($urandom_range(2, 60)));
`endif
            tick();
        end

`ifndef LED_SERIAL_TX_PEND_EN
        // start held high: back-to-back frames with exactly one idle cycle.
        bus.start = 1'b1;
        bus.data  = 16'hFFFF;
        tick();
        bus.data  = 16'h0001;
        monitor_frame(-1, 16'h0001, bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        check("b2b_f1_bits", 32'(bits), 32'(16'hFFFF));
        check("b2b_f1_busy", 32'(busy_len), 32'(FRAME));
        check("b2b_gap", 32'(bus.busy), 32'(0));
        tick();
        check("b2b_f2_start", 32'(bus.busy), 32'(1));
        bus.start = 1'b0;
        monitor_frame(-1, 16'h0000, bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        check("b2b_f2_bits", 32'(bits), 32'(16'h0001));
        check("b2b_f2_busy", 32'(busy_len), 32'(FRAME));
        check("b2b_f2_edges", 32'(edges), 32'(DW));
        tick();
`endif

        // Reset at cycle 30 of a frame aborts it without a done pulse.
        start_frame(16'h5A5A);
        repeat (29) tick();
        check("mid_busy_before", 32'(bus.busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy),     32'(0));
        check("mid_rst_clk",  32'(bus.led_clk),  32'(1));
        check("mid_rst_clrn", 32'(bus.led_clrn), 32'(0));
        check("mid_rst_pen",  32'(bus.led_pen),  32'(0));
        check("mid_rst_sout", 32'(bus.led_sout), 32'(0));
        for (int j = 0; j < 2; j++) begin
            tick();
            check($sformatf("mid_rst_nodone%0d", j), 32'(bus.done), 32'(0));
        end
        rst = 1'b0;
        tick();
        check("mid_rel_clrn", 32'(bus.led_clrn), 32'(1));
        check("mid_rel_busy", 32'(bus.busy), 32'(0));
        start_frame(16'h8000);
        check("post_rst_first_bit", 32'(bus.led_sout), 32'(1));
        monitor_frame(-1, 16'h0000, bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        check("post_rst_bits", 32'(bits), 32'(16'h8000));
        check("post_rst_busy", 32'(busy_len), 32'(FRAME));
        check("post_rst_edges", 32'(edges), 32'(DW));
        tick();

`ifdef LED_SERIAL_TX_PEND_EN
        // Pending request chains straight into a second frame.
        start_frame(16'h1234);
        monitor_frame(10, 16'h00FF, bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        check("pend_f1_bits", 32'(bits), 32'(16'h1234));
        check("pend_f1_busy", 32'(busy_len), 32'(FRAME));
        check("pend_at_done", 32'(pend_at_done), 32'(1));
        check("pend_nogap_busy", 32'(bus.busy), 32'(1));
        check("pend_cleared", 32'(bus.pend), 32'(0));
        check("pend_f2_clk", 32'(bus.led_clk), 32'(0));
        monitor_frame(-1, 16'h0000, bits, busy_len, done_at, pen_cnt, edges, pend_at_done);
        check("pend_f2_bits", 32'(bits), 32'(16'h00FF));
        check("pend_f2_busy", 32'(busy_len), 32'(FRAME));
        check("pend_f2_idle", 32'(bus.busy), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
